array_masked_clr_ext: RTL
=========================

# array_masked_clr_ext

Parametrised single-port masked SRAM model for behavioural simulation of generated `*_ext` memory macros. It generalises the fixed 32x2 bit-masked array to any depth, width and mask granularity. It adds a registered read path with selectable latency, a read-valid strobe, and a hardware clear engine that zeroes the array after reset or on request. It sits under the generated memory wrappers and is used wherever a macro needs deterministic contents at start-up.

## Interface
- `DEPTH`, default 32: number of words; must be ≥2.
- `WIDTH`, default 2: bits per word.
- `MASK_GRAN`, default 1: bits per mask lane; `WIDTH % MASK_GRAN != 0` is an elaboration error.
- `READ_LATENCY`, default 1: 1 or 2 cycles from accepted read to data; any other value is an elaboration error.
- `CLEAR_ON_RESET`, default 1: 1 means the clear engine runs automatically after reset.
- Derived: `AW = max(1, $clog2(DEPTH))`; `ML = WIDTH/MASK_GRAN`.

Ports:
- `RW0_clk`  in  1  sole clock; all state changes on its rising edge.
- `RW0_reset`  in  1  asynchronous, active-high reset.
- `RW0_addr`  in  AW  word address; values ≥ DEPTH are ignored (no write, read returns 0).
- `RW0_en`  in  1  access request.
- `RW0_wmode`  in  1  1 = write, 0 = read.
- `RW0_wmask`  in  ML  bit i enables `wdata[i*MASK_GRAN +: MASK_GRAN]`.
- `RW0_wdata`  in  WIDTH  write data.
- `RW0_clear`  in  1  single-cycle request to zero the whole array.
- `RW0_ready`  out  1  high when requests are accepted.
- `RW0_rdata`  out  WIDTH  registered read data; holds the last read value.
- `RW0_rvalid`  out  1  one-cycle strobe marking new `RW0_rdata`.

## Operation
- **States:** CLEAR, READY.
- **Reset:** the async reset forces the following:
  - state = CLEAR if `CLEAR_ON_RESET`, else READY;
  - clear counter = 0;
  - `RW0_rdata` = 0, `RW0_rvalid` = 0;
  - the pipeline stage-valid flag = 0.
  - Array contents are not touched by reset itself.
- **`RW0_ready`:** equals (state == READY), taken from the registered state.
- **CLEAR state:**
  - Each cycle writes all-zero to `ram[cnt]`, then `cnt++`.
  - After writing `cnt == DEPTH-1`, goes to READY.
  - `RW0_en` and `RW0_clear` are ignored while in CLEAR.
- **READY state, accepted request:** a request is accepted when `RW0_en && RW0_ready`.
  - Write (`wmode=1`): only lanes with mask bit set are updated; other lanes keep their old value.
  - Read (`wmode=0`): captures `ram[addr]` into the read pipeline.
- **`RW0_clear` in READY:** state becomes CLEAR at the next edge with `cnt = 0`.
  - If `RW0_en` is high in the same cycle, the request is still accepted and executed in that cycle.
  - Clearing starts on the following cycle.
- **Read pipeline:** an in-flight read (latency 2) always completes, even if CLEAR begins or a write follows.
- **Data hold:** `RW0_rdata` changes only when `RW0_rvalid` is asserted; otherwise it holds. It never shows random or garbage data.
- **Writes:** produce no `rvalid`.

## Timing
- **Read, latency 1:** accepted at edge N → `rdata` and `rvalid=1` valid after edge N; `rvalid` drops after N+1 unless another read is accepted.
- **Read, latency 2:** accepted at edge N → valid after edge N+1. Back-to-back reads give one result per cycle.
- **Read after write:** a write at edge N is visible to a read accepted at edge N+1.
- **Clear duration:**
  - After reset release, CLEAR lasts exactly DEPTH cycles.
  - `RW0_ready` rises after the edge that writes address DEPTH-1.
  - The first accept is possible at that following edge.
- **Reset mid-clear:** the counter restarts at 0 and clearing runs the full DEPTH cycles again.
- **Reset mid-read:** the pending `rvalid` is dropped.
- **Counter width:** AW bits. Termination is by comparison with DEPTH-1, so non-power-of-two depths never wrap past the end.

## Test plan
- **Reset clear:** DEPTH=32, WIDTH=8, MASK_GRAN=4, CLEAR_ON_RESET=1; release reset → `RW0_ready` low for exactly 32 cycles. Reading addresses 0..31 then returns 0x00 each, with `rvalid` one cycle after accept.
- **Masked write:**
  - Write 0xAB to addr 5, mask 2'b11; write 0xCD to addr 5, mask 2'b01; read addr 5 → 0xAD.
  - Write 0x3F mask 2'b10 → subsequent read 0x3D.
- **Latency 2, back-to-back reads:** READ_LATENCY=2, reads of addrs 1, 2, 3 on consecutive cycles (contents 0x11, 0x22, 0x33) → `rvalid` high three consecutive cycles starting two edges after the first accept, with data in order. `rdata` holds 0x33 afterwards.
- **Clear with concurrent write:**
  - `RW0_clear` with a write of 0x77 to addr 7 in the same cycle → write accepted, `ready` low for the next 32 cycles.
  - Read addr 7 afterwards → 0x00.
  - `RW0_en` pulses during CLEAR → no effect, no `rvalid`.
- **Reset mid-clear:**
  - Assert reset at clear cycle 10 → outputs return to 0 immediately (async).
  - After release, `ready` stays low a full 32 cycles.
- **No auto-clear:** CLEAR_ON_RESET=0 → `ready` high one cycle after reset release. Addr ≥ DEPTH (DEPTH=24, addr 30): write ignored, read returns 0 with `rvalid`.

Source files
------------

// File: rtl/array_masked_clr_ext.sv
// array_masked_clr_ext: parametrised masked single-port SRAM model with registered read path and clear engine
module array_masked_clr_ext #(
    parameter int DEPTH          = 32,
    parameter int WIDTH          = 2,
    parameter int MASK_GRAN      = 1,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
    localparam int ML = WIDTH / MASK_GRAN
) (
    input  logic             RW0_clk,
    input  logic             RW0_reset,
    input  logic [AW-1:0]    RW0_addr,
    input  logic             RW0_en,
    input  logic             RW0_wmode,
    input  logic [ML-1:0]    RW0_wmask,
    input  logic [WIDTH-1:0] RW0_wdata,
    input  logic             RW0_clear,
    output logic             RW0_ready,
    output logic [WIDTH-1:0] RW0_rdata,
    output logic             RW0_rvalid
);
    if (DEPTH < 2) begin : g_depth_err
        $error("array_masked_clr_ext: DEPTH must be at least 2");
    end
    if (WIDTH % MASK_GRAN != 0) begin : g_gran_err
        $error("array_masked_clr_ext: WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_lat_err
        $error("array_masked_clr_ext: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] bmask;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] out_data;
    logic             in_rng;
    logic             acc;
    logic             rd_acc;
    logic             s1_valid;
    logic             out_valid;

    assign RW0_ready = state == READY;
    assign in_rng    = {1'b0, RW0_addr} < DEPTH_W;
    assign acc       = RW0_en && RW0_ready;
    assign rd_acc    = acc && !RW0_wmode;
    assign rd_word   = in_rng ? ram[RW0_addr] : '0;
    assign out_valid = READ_LATENCY == 2 ? s1_valid : rd_acc;
    assign out_data  = READ_LATENCY == 2 ? s1_data : rd_word;

    // expand per-lane mask bits to a per-bit write mask
    always_comb begin
        bmask = '0;
        for (int i = 0; i < ML; i++)
            bmask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{RW0_wmask[i]}};
    end

    // array: clear engine zeroes one word per cycle, otherwise masked writes merge lanes
    always_ff @(posedge RW0_clk) begin
        if (state == CLEAR)
            ram[cnt] <= '0;
        else if (acc && RW0_wmode && in_rng)
            ram[RW0_addr] <= (ram[RW0_addr] & ~bmask) | (RW0_wdata & bmask);
    end

    // control: walk cnt to DEPTH-1 while clearing, re-enter CLEAR on request
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            state <= cnt == LAST ? READY : CLEAR;
            cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
        end else if (RW0_clear) begin
            state <= CLEAR;
            cnt   <= '0;
        end
    end

    // read pipeline: rdata only updates alongside rvalid; in-flight reads survive a clear
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            RW0_rvalid <= 1'b0;
            RW0_rdata  <= '0;
        end else begin
            s1_valid   <= rd_acc;
            s1_data    <= rd_word;
            RW0_rvalid <= out_valid;
            if (out_valid)
                RW0_rdata <= out_data;
        end
    end
endmodule
